// File: rtl/config_chain_loader_if.sv
// Host word stream into the configuration chain loader.
// Handshake: a word transfers on a rising clk edge where word_valid and word_ready
// are both high; word_data must be stable while word_valid is high, and the loader
// only raises word_ready when it is waiting for the next word.
interface config_chain_loader_if #(
    parameter int WORD_W = 32
);
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready;

    modport master (
        output word_valid,
        output word_data,
        input  word_ready
    );

    modport slave (
        input  word_valid,
        input  word_data,
        output word_ready
    );
endinterface

// File: rtl/config_chain_loader.sv
// Serialises host configuration words onto a tile scan chain (LSB first), strobes
// cset to latch the new configuration, and reports the parity of the displaced bits.
module config_chain_loader #(
    parameter int CHAIN_LEN = 4368,
    parameter int WORD_W    = 32,
    parameter int CSET_CYC  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    config_chain_loader_if.slave  host,
    output logic                  cen,
    output logic                  shift_in,
    input  logic                  shift_out,
    output logic                  cset,
    output logic                  busy,
    output logic                  done,
    output logic                  rb_parity,
    output logic [2:0]            dbg_state
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] SET   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WB_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int SC_W  = (CSET_CYC > 1) ? $clog2(CSET_CYC) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WB_W-1:0]  WORD_LAST = WB_W'(WORD_W - 1);
    localparam logic [SC_W-1:0]  SET_LAST  = SC_W'(CSET_CYC - 1);

    logic [2:0]        state;
    logic [2:0]        state_d;
    logic [WORD_W-1:0] word_buf;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WB_W-1:0]   word_bit;
    logic [SC_W-1:0]   set_cnt;

    // Next-state selection; the chain-length test wins over the word-boundary test
    // so the unused high bits of the final word are simply dropped.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (host.word_valid) state_d = SHIFT;
            SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    state_d = SET;
                end else if (word_bit == WORD_LAST) begin
                    state_d = LOAD;
                end
            end
            SET:     if (set_cnt == SET_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; an asynchronous reset aborts any load before cset is raised.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Datapath: word buffer, bit counters, cset hold counter and readback parity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_buf  <= '0;
            bit_cnt   <= '0;
            word_bit  <= '0;
            set_cnt   <= '0;
            rb_parity <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bit_cnt   <= '0;
                        rb_parity <= 1'b0;
                    end
                end
                LOAD: begin
                    if (host.word_valid) begin
                        word_buf <= host.word_data;
                        word_bit <= '0;
                    end
                end
                SHIFT: begin
                    word_buf  <= word_buf >> 1;
                    bit_cnt   <= bit_cnt + 1'b1;
                    word_bit  <= word_bit + 1'b1;
                    rb_parity <= rb_parity ^ shift_out;
                    if (bit_cnt == LAST_BIT) begin
                        set_cnt <= '0;
                    end
                end
                SET: begin
                    if (set_cnt != SET_LAST) begin
                        set_cnt <= set_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode directly from state so reset clears them immediately.
    assign host.word_ready = (state == LOAD);
    assign cen             = (state == SHIFT);
    assign shift_in        = cen & word_buf[0];
    assign cset            = (state == SET);
    assign busy            = (state != IDLE);
    assign done            = (state == DONE);
    assign dbg_state       = state;

endmodule
